// File: rtl/fade_pkg.sv
// Shared types for the RGB hue-wheel fade sequencer: phase encoding, FSM states
// and phase-stepping helpers.
package fade_pkg;

  localparam int unsigned NUM_PHASES = 6;
  localparam int unsigned PHASE_W    = 3;

  typedef enum logic [PHASE_W-1:0] {
    GREEN_INC = 3'd0,
    RED_DEC   = 3'd1,
    BLUE_INC  = 3'd2,
    GREEN_DEC = 3'd3,
    RED_INC   = 3'd4,
    BLUE_DEC  = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Out-of-range command phases fall back to the start of the wheel.
  function automatic phase_t coerce_phase(input logic [PHASE_W-1:0] p);
    return (p > 3'd5) ? GREEN_INC : phase_t'(p);
  endfunction

  function automatic phase_t phase_fwd(input phase_t p);
    return (p == BLUE_DEC) ? GREEN_INC : phase_t'(p + 3'd1);
  endfunction

  function automatic phase_t phase_rev(input phase_t p);
    return (p == GREEN_INC) ? BLUE_DEC : phase_t'(p - 3'd1);
  endfunction

endpackage

// File: rtl/fade_sequencer_if.sv
// Command port of the fade sequencer: valid/ready handshake carrying a start
// phase and a new step divider.
interface fade_sequencer_if
  import fade_pkg::*;
#(
  parameter int unsigned DIV_W = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [PHASE_W-1:0] cmd_phase;
  logic [DIV_W-1:0]   cmd_div;

  modport master (output cmd_valid, cmd_phase, cmd_div, input cmd_ready);
  modport slave  (input cmd_valid, cmd_phase, cmd_div, output cmd_ready);
endinterface

// File: rtl/fade_prescaler.sv
// Step prescaler: counts 0..div-1 while enabled and flags the last count as a
// tick. A divider of 0 behaves like 1 (tick every enabled cycle).
module fade_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] last;

  assign last = (div == '0) ? '0 : div - DIV_W'(1);
  assign tick = en && (count >= last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= tick ? '0 : count + DIV_W'(1);
  end
endmodule

// File: rtl/fade_sequencer.sv
// RGB hue-wheel fade sequencer: steps phase/level on prescaler ticks and derives
// three channel duties. Define FADE_REVERSE_EN to add the dir input (reverse walk).
module fade_sequencer
  import fade_pkg::*;
#(
  parameter  int unsigned PWM_INTERVAL = 1000,
  parameter  int unsigned STEP_DIV     = 1200,
  parameter  int unsigned DIV_W        = 16,
  localparam int unsigned DUTY_W       = $clog2(PWM_INTERVAL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef FADE_REVERSE_EN
  input  logic              dir,
`endif
  fade_sequencer_if.slave   cmd,
  output logic [DUTY_W-1:0] red_duty,
  output logic [DUTY_W-1:0] green_duty,
  output logic [DUTY_W-1:0] blue_duty,
  output phase_t            phase,
  output logic              cycle_done
);
  localparam logic [DUTY_W-1:0] FULL     = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] LVL_LAST = DUTY_W'(PWM_INTERVAL - 1);

  state_t            state, state_nx;
  logic [DUTY_W-1:0] level;
  logic [DIV_W-1:0]  div;
  logic              accept, tick, step, wrap, rev, pre_en;

`ifdef FADE_REVERSE_EN
  assign rev = dir;
`else
  assign rev = 1'b0;
`endif

  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  // A command arriving with a tick wins; the tick is dropped.
  assign step   = tick && !accept;
  assign wrap   = rev ? (phase == GREEN_INC && level == '0)
                      : (phase == BLUE_DEC && level == LVL_LAST);
  assign pre_en = run && (state == RUN);

  fade_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (accept),
    .div  (div),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HOLD;
      cmd.cmd_ready <= 1'b1;
    end else begin
      state         <= state_nx;
      cmd.cmd_ready <= (state_nx != LOAD);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      HOLD:    if (accept) state_nx = LOAD; else if (run)  state_nx = RUN;
      RUN:     if (accept) state_nx = LOAD; else if (!run) state_nx = HOLD;
      LOAD:    state_nx = run ? RUN : HOLD;
      default: state_nx = HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= GREEN_INC;
      level      <= '0;
      div        <= DIV_W'(STEP_DIV);
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= step && wrap;
      if (accept) begin
        phase <= coerce_phase(cmd.cmd_phase);
        level <= '0;
        div   <= cmd.cmd_div;
      end else if (step) begin
        if (rev) begin
          if (level == '0) begin
            level <= LVL_LAST;
            phase <= phase_rev(phase);
          end else begin
            level <= level - DUTY_W'(1);
          end
        end else begin
          if (level == LVL_LAST) begin
            level <= '0;
            phase <= phase_fwd(phase);
          end else begin
            level <= level + DUTY_W'(1);
          end
        end
      end
    end
  end

  // Ramping channel is level on INC phases and FULL-level on DEC phases.
  always_comb begin
    red_duty   = '0;
    green_duty = '0;
    blue_duty  = '0;
    case (phase)
      GREEN_INC: begin red_duty   = FULL;         green_duty = level;        end
      RED_DEC:   begin red_duty   = FULL - level; green_duty = FULL;         end
      BLUE_INC:  begin green_duty = FULL;         blue_duty  = level;        end
      GREEN_DEC: begin green_duty = FULL - level; blue_duty  = FULL;         end
      RED_INC:   begin red_duty   = level;        blue_duty  = FULL;         end
      BLUE_DEC:  begin red_duty   = FULL;         blue_duty  = FULL - level; end
      default:   ;
    endcase
  end
endmodule

// File: tb/tb_fade_sequencer.sv
// Bench for fade_sequencer: wheel-position model checked every cycle plus
// directed literal expectations (PWM_INTERVAL=4, STEP_DIV=2).
module tb_fade_sequencer;
  localparam int P      = 4;
  localparam int SDIV   = 2;
  localparam int DUTY_W = $clog2(P + 1);
  localparam int WHEEL  = 6 * P;
  // Channel role per phase: 0=off, 1=full, 2=level, 3=P-level.
  localparam int ROLE [6][3] = '{'{1, 2, 0}, '{3, 1, 0}, '{0, 1, 2},
                                 '{0, 3, 1}, '{2, 0, 1}, '{1, 0, 3}};

  logic clk, rst, run, dir;
  logic [DUTY_W-1:0] red_duty, green_duty, blue_duty;
  logic [2:0] phase;
  logic cycle_done;
  int vectors = 0, misc = 0;

  fade_sequencer_if #(.DIV_W(16)) cmd_if ();

  fade_sequencer #(.PWM_INTERVAL(P), .STEP_DIV(SDIV), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
`ifdef FADE_REVERSE_EN
    .dir        (dir),
`endif
    .cmd        (cmd_if),
    .red_duty   (red_duty),
    .green_duty (green_duty),
    .blue_duty  (blue_duty),
    .phase      (phase),
    .cycle_done (cycle_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position on the wheel, run-mode, prescaler count and divider.
  int m_mode, m_cnt, m_div, m_pos;
  bit m_done;
  logic m_acc, m_counting, m_tick, m_wrap, m_rev;
  int m_next;

`ifdef FADE_REVERSE_EN
  assign m_rev = dir;
`else
  assign m_rev = 1'b0;
`endif
  assign m_acc      = cmd_if.cmd_valid && (m_mode != 2);
  assign m_counting = (m_mode == 1) && run;
  assign m_tick     = m_counting && (m_cnt == ((m_div == 0) ? 1 : m_div) - 1);
  assign m_wrap     = m_rev ? (m_pos == 0) : (m_pos == WHEEL - 1);
  assign m_next     = m_rev ? (m_pos + WHEEL - 1) % WHEEL : (m_pos + 1) % WHEEL;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_cnt <= 0; m_div <= SDIV; m_pos <= 0; m_done <= 1'b0;
    end else begin
      m_mode <= m_acc ? 2 : (run ? 1 : 0);
      m_done <= 1'b0;
      if (m_acc) begin
        m_pos <= ((cmd_if.cmd_phase > 3'd5) ? 0 : int'(cmd_if.cmd_phase)) * P;
        m_cnt <= 0;
        m_div <= int'(cmd_if.cmd_div);
      end else if (m_counting) begin
        m_cnt <= m_tick ? 0 : m_cnt + 1;
        if (m_tick) begin
          m_pos  <= m_next;
          m_done <= m_wrap;
        end
      end
    end
  end

  function automatic int exp_duty(input int ch, input int pos);
    int lv = pos % P;
    case (ROLE[pos / P][ch])
      0:       return 0;
      1:       return P;
      2:       return lv;
      default: return P - lv;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check("model_red",   32'(red_duty),   exp_duty(0, m_pos));
    check("model_green", 32'(green_duty), exp_duty(1, m_pos));
    check("model_blue",  32'(blue_duty),  exp_duty(2, m_pos));
    check("model_phase", 32'(phase),      m_pos / P);
    check("model_done",  32'(cycle_done), int'(m_done));
    check("model_ready", 32'(cmd_if.cmd_ready), int'(m_mode != 2));
  end

  task automatic send_cmd(input int ph, input int dv);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_phase = 3'(ph);
    cmd_if.cmd_div   = 16'(dv);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_for(input int ph, input int b, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (phase == 3'(ph) && blue_duty == DUTY_W'(b)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_rgb(input string tag, input int r, input int g, input int b, input int ph);
    check({tag, "_r"}, 32'(red_duty), r);
    check({tag, "_g"}, 32'(green_duty), g);
    check({tag, "_b"}, 32'(blue_duty), b);
    check({tag, "_phase"}, 32'(phase), ph);
  endtask

  initial begin
    int n_done, first_done;
    bit found;
    rst = 1'b1; run = 1'b0; dir = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_phase = '0; cmd_if.cmd_div = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_rgb("reset", 4, 0, 0, 0);
    check("reset_ready", 32'(cmd_if.cmd_ready), 1);
    repeat (20) @(negedge clk);
    check_rgb("hold20", 4, 0, 0, 0);

    // One cycle to enter RUN, then a tick every 2 cycles.
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("run_g1", 32'(green_duty), 1);
    repeat (4) @(negedge clk);
    check("run_g3", 32'(green_duty), 3);
    repeat (2) @(negedge clk);
    check_rgb("run_ph1", 4, 4, 0, 1);
    n_done = 0; first_done = -1;
    for (int i = 10; i <= 52; i++) begin
      @(negedge clk);
      if (cycle_done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
    end
    check("done_count", 32'(n_done), 1);
    check("done_cycle", 32'(first_done), 49);

    send_cmd(3, 1);
    check("cmd_ready_low", 32'(cmd_if.cmd_ready), 0);
    check_rgb("cmd3", 0, 4, 4, 3);
    @(negedge clk);
    check("cmd_ready_back", 32'(cmd_if.cmd_ready), 1);
    check("cmd3_g4", 32'(green_duty), 4);
    @(negedge clk); check("cmd3_g3", 32'(green_duty), 3);
    @(negedge clk); check("cmd3_g2", 32'(green_duty), 2);
    @(negedge clk); check("cmd3_g1", 32'(green_duty), 1);
    @(negedge clk); check_rgb("cmd3_ph4", 0, 0, 4, 4);

    send_cmd(7, 0);
    check_rgb("cmd7", 4, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("div0_g1", 32'(green_duty), 1);
    @(negedge clk);
    check("div0_g2", 32'(green_duty), 2);

    // Land a command on the 5->0 wrap tick.
    wait_for(5, 1, 40, found);
    check("wait_wrap", 32'(found), 1);
    send_cmd(2, 0);
    check("wrap_cmd_done", 32'(cycle_done), 0);
    check("wrap_cmd_phase", 32'(phase), 2);
    @(negedge clk);
    check("wrap_cmd_done2", 32'(cycle_done), 0);

    wait_for(2, 3, 10, found);
    check("wait_lvl3", 32'(found), 1);
    #2 rst = 1'b1;
    #1;
    check_rgb("async_rst", 4, 0, 0, 0);
    check("async_rst_ready", 32'(cmd_if.cmd_ready), 1);
    check("async_rst_done", 32'(cycle_done), 0);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;

`ifdef FADE_REVERSE_EN
    dir = 1'b1; run = 1'b1;
    repeat (3) @(negedge clk);
    check_rgb("rev_step", 4, 0, 1, 5);
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fade_sequencer.md
# fade_sequencer

Sequencing controller for the RGB hue-wheel fade. Walks the six-phase colour wheel one duty step per prescaler tick and presents three per-channel duty values to the PWM generators. Supports run/hold and a valid/ready command port that loads a start phase and a step divider. Sits between the top-level control and the three PWM output channels.

## Interface
- PWM_INTERVAL, 1000: full-scale duty value; each phase has PWM_INTERVAL steps.
- STEP_DIV, 1200: reset value of the step divider, in clk cycles per step.
- DIV_W, 16: divider width.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- run  in  1  1 = advance on ticks; 0 = hold the current colour.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted.
- cmd_phase  in  3  start phase, encoded as phase_t.
- cmd_div  in  DIV_W  new step divider.
- red_duty, green_duty, blue_duty  out  DUTY_W each  channel duties; DUTY_W = $clog2(PWM_INTERVAL+1).
- phase  out  3  current phase.
- cycle_done  out  1  one-cycle pulse on wheel wrap.

## Operation
- Phase encoding: GREEN_INC=0, RED_DEC=1, BLUE_INC=2, GREEN_DEC=3, RED_INC=4, BLUE_DEC=5.
- The level register runs 0..PWM_INTERVAL-1 within a phase.
- The ramping channel is level in INC phases and PWM_INTERVAL-level in DEC phases.
- Channel values per phase: GREEN_INC R=full, B=0; RED_DEC G=full, B=0; BLUE_INC R=0, G=full; GREEN_DEC R=0, B=full; RED_INC G=0, B=full; BLUE_DEC R=full, G=0.
- Duties are combinational from the phase and level registers.
- Tick: the prescaler counts 0..div-1 while run=1 and the FSM is in RUN. The tick is the cycle in which the count equals div-1. A div of 0 is treated as 1, giving a tick every cycle.
- Forward step: level==PWM_INTERVAL-1 → level=0, phase=(phase+1) mod 6. Otherwise level+1.
- Forward wrap 5→0 raises cycle_done for one cycle.
- FSM states are HOLD, RUN and LOAD.
  - HOLD: run=0. Prescaler frozen, not cleared.
  - HOLD→RUN when run=1; RUN→HOLD when run=0.
  - Accepting a command (cmd_valid&&cmd_ready) from HOLD or RUN → LOAD.
  - LOAD lasts one cycle with cmd_ready=0, then goes to RUN if run=1, else HOLD.
- cmd_ready=1 in HOLD and RUN.
- On accept, the next edge sets phase=cmd_phase, level=0, prescaler=0 and div=cmd_div.
- A cmd_phase value greater than 5 is coerced to GREEN_INC.
- A tick coinciding with an accept is discarded; the command wins.
- A command that lands on a phase-5→0 wrap tick does not pulse cycle_done.

## Timing
- Reset values: phase=0, level=0, prescaler=0, div=STEP_DIV, FSM=HOLD, cmd_ready=1, cycle_done=0, red_duty=PWM_INTERVAL, green_duty=0, blue_duty=0.
- Duty outputs change on the same edge that updates level or phase.
- Level-to-duty latency is 0 cycles.
- Command latency: phase, level and duties reflect the command 1 cycle after the accept edge.
- The earliest tick after a command is div cycles after leaving LOAD.
- Back-to-back commands are spaced at least 2 cycles apart, because of LOAD.
- rst asserted mid-phase or in LOAD returns immediately to the reset values. A pending command is dropped.

## Configuration
- FADE_REVERSE_EN defined:
  - Adds input `dir` (1 bit, 1 = reverse), sampled on each tick.
  - Reverse step: level==0 → level=PWM_INTERVAL-1, phase=(phase+5) mod 6. Otherwise level-1.
  - Reverse wrap 0→5 pulses cycle_done.
- FADE_REVERSE_EN undefined: the `dir` port is absent and the block steps forward only.

## Structure
- Package fade_pkg holds:
  - phase_t, a 3-bit enum of the six phases.
  - NUM_PHASES=6.
  - the FSM state enum (HOLD/RUN/LOAD).
- Sub-module fade_prescaler owns the divider counter.
  - Inputs: en, clr, div. Output: tick.
  - Instantiated once.

## Test plan
- Reset with PWM_INTERVAL=4, STEP_DIV=2, run=0 → duties R=4, G=0, B=0, phase=0, cmd_ready=1. Holding 20 cycles leaves everything unchanged.
- run=1, same parameters → G steps 0,1,2,3 every 2 cycles. Phase becomes 1 after 8 cycles with R=4, G=4. cycle_done pulses once after 48 cycles.
- Command cmd_phase=3, cmd_div=1 while running:
  - cmd_ready low for one cycle.
  - Next cycle phase=3, R=0, G=4, B=4.
  - G then decrements every cycle.
- cmd_phase=7 → phase=0. cmd_div=0 → one step per cycle.
- Command asserted on the same cycle as a 5→0 wrap tick → no cycle_done pulse; phase = cmd_phase.
- Async rst asserted mid-phase 2 (level 3) → outputs return to reset values without a clock edge.
- FADE_REVERSE_EN build, dir=1 from reset → next step gives phase=5, level=3, B=1, R=4.
